// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like memory port between the instruction
// fetch and data requesters. Data wins over instruction. A request that is
// presented but not yet accepted is locked on the bus until addr_ok. Accepted
// transactions are queued in order so each data_ok returns to its issuer.
// Optional feature macro: MEM_ARB_FLUSH_EN (flush discards pending inst responses).
module mem_port_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  input  logic        flush,

  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [AW:0]      wptr_q, rptr_q;
  logic [DEPTH-1:0] id_q;
  logic [AW-1:0]    widx, ridx;
  logic             full, empty;
  logic             sel_i, sel_d;
  logic             req_int, accept, pop;
  logic             head_id, head_disc;

  assign widx  = wptr_q[AW-1:0];
  assign ridx  = rptr_q[AW-1:0];
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (widx == ridx);
  assign empty = (wptr_q == rptr_q);

  // Select the requester that owns the bus this cycle.
  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!full) begin
          if (data_req)      sel_d = 1'b1;
          else if (inst_req) sel_i = 1'b1;
        end
      end
      LOCK_I: sel_i = 1'b1;
      LOCK_D: sel_d = 1'b1;
      default: ;
    endcase
  end

  // Drive the shared bus from the selected side; zeros when nobody is selected.
  always_comb begin
    wr    = 1'b0;
    size  = '0;
    addr  = '0;
    wstrb = '0;
    wdata = '0;
    if (sel_d) begin
      wr    = data_wr;
      size  = data_size;
      addr  = data_addr;
      wstrb = data_wstrb;
      wdata = data_wdata;
    end else if (sel_i) begin
      wr    = inst_wr;
      size  = inst_size;
      addr  = inst_addr;
      wstrb = inst_wstrb;
      wdata = inst_wdata;
    end
  end

  assign req_int      = ((sel_d & data_req) | (sel_i & inst_req)) & ~full & resetn;
  assign req          = req_int;
  assign accept       = req_int & addr_ok;
  assign data_addr_ok = accept & sel_d;
  assign inst_addr_ok = accept & sel_i;

  // Lock next-state: stay on a presented request until the slave takes it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_int && !addr_ok) state_d = sel_d ? LOCK_D : LOCK_I;
      end
      LOCK_I, LOCK_D: begin
        if (accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Lock state and in-order transaction FIFO.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q[widx] <= sel_d;
        wptr_q     <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
    end
  end

`ifdef MEM_ARB_FLUSH_EN
  logic [DEPTH-1:0] disc_q;

  // Flush marks every queued inst entry as discarded; stale slots are harmless
  // since a push always rewrites its own discard bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      disc_q <= '0;
    end else begin
      if (flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (!id_q[i]) disc_q[i] <= 1'b1;
        end
      end
      if (accept) disc_q[widx] <= flush & ~sel_d;
    end
  end

  assign head_disc = disc_q[ridx];
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign head_disc    = 1'b0;
`endif

  assign head_id      = id_q[ridx];
  assign pop          = data_ok & ~empty & resetn;
  assign data_data_ok = pop & head_id;
  assign inst_data_ok = pop & ~head_id & ~head_disc;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (EX issues loads/stores, MEM consumes `data_sram_rdata`). It grants one request per cycle, with data taking priority over instruction. It holds a granted request stable until the slave accepts it. It tracks accepted-but-unanswered transactions in an in-order FIFO so each `data_ok` returns to the requester that issued it.

## Interface
Parameters:
- `DEPTH`, 4: max outstanding accepted transactions; power of two, 2..16.

Ports. Reset is `resetn`, synchronous, active-low; clock is `clk`.
- `clk`  in  1  clock
- `resetn`  in  1  synchronous active-low reset
- `inst_req`  in  1  IF request valid
- `inst_wr`  in  1  IF write (always 0 in practice; passed through)
- `inst_size`  in  2  IF size (0=byte, 1=half, 2=word)
- `inst_addr`  in  32  IF address
- `inst_wstrb`  in  4  IF byte strobes
- `inst_wdata`  in  32  IF write data
- `inst_addr_ok`  out  1  IF request accepted this cycle
- `inst_data_ok`  out  1  IF response valid this cycle
- `inst_rdata`  out  32  IF read data
- `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wstrb`, `data_wdata`  in  1/1/2/32/4/32  data-side request, same meanings as the IF inputs
- `data_addr_ok`, `data_data_ok`  out  1  data-side accept and response
- `data_rdata`  out  32  data-side read data
- `flush`  in  1  pipeline flush (ertn/exception); used only under the config macro
- `req`, `wr`, `size`, `addr`, `wstrb`, `wdata`  out  1/1/2/32/4/32  shared slave request
- `addr_ok`  in  1  slave accepted request
- `data_ok`  in  1  slave response valid
- `rdata`  in  32  slave read data

## Operation
- Lock FSM states: `IDLE`, `LOCK_I`, `LOCK_D`. Reset puts the FSM in `IDLE`.
- `IDLE` selection:
  - `data_req` wins. Otherwise `inst_req` wins. Otherwise nothing is selected.
  - A selection is made only when the FIFO is not full.
  - If the selected request is presented without `addr_ok`, the FSM moves to `LOCK_D` or `LOCK_I`.
- `LOCK_x`:
  - The bus is driven only from requester x, even if the other side requests.
  - When `addr_ok` arrives, the FSM returns to `IDLE`.
  - Requesters must hold `req` and payload stable until their `addr_ok`. The block does not check this.
- Bus output:
  - `req` = selected requester's req AND NOT full.
  - `wr`, `size`, `addr`, `wstrb`, `wdata` are muxed from the selected side. They are 0 when nothing is selected.
- Accept:
  - Accept = `req & addr_ok`.
  - On accept, the selected side's `*_addr_ok` is 1 (combinational), and an entry {id, discard=0} is pushed. id is 0 for inst, 1 for data.
- Response:
  - On `data_ok`, the head entry is popped.
  - If the head id is 1, `data_data_ok` = 1. If the head id is 0 and discard is 0, `inst_data_ok` = 1.
  - `rdata` is fanned out to both `*_rdata` unconditionally.
- FIFO:
  - Circular buffer with log2(DEPTH)+1-bit read and write pointers. Pointers wrap modulo 2·DEPTH.
  - full = pointers differ only in MSB. empty = pointers equal.
  - Push and pop in the same cycle are both performed.
  - Full blocks push even when a pop occurs in the same cycle.
- `data_ok` while empty: ignored, no pop, no `*_data_ok`.

## Timing
- `*_addr_ok` and `*_data_ok` are combinational in the same cycle as the bus `addr_ok`/`data_ok`. There is zero added latency.
- Arbitration is combinational from the current FSM state and the request inputs. The FSM and FIFO update on `posedge clk`.
- Reset behaviour:
  - While `resetn`=0: `req`, `inst_addr_ok`, `data_addr_ok`, `inst_data_ok`, `data_data_ok` are forced to 0.
  - On the reset edge: FIFO is emptied, FSM goes to `IDLE`, all discard bits are cleared.
  - Reset in the middle of an operation abandons any in-flight entries. The slave is reset together with this block.
- Throughput: one accept and one response per cycle.

## Configuration
- `MEM_ARB_FLUSH_EN` defined:
  - On a cycle with `flush`=1, every valid FIFO entry with id=0 gets discard=1.
  - An inst request accepted in the same cycle is pushed with discard=1.
  - Discarded entries still pop on `data_ok` but assert no `inst_data_ok`.
  - Data entries are never discarded.
  - The `LOCK_I` state is still held until `addr_ok`.
- Not defined: `flush` is ignored, the discard bits are not implemented, and every entry produces a response.

## Test plan
- Arbitration priority:
  - Stimulus: `inst_req`=1 and `data_req`=1 in the same cycle, `addr_ok`=1.
  - Required: `data_addr_ok`=1, `inst_addr_ok`=0, `addr` = `data_addr`. The inst request is accepted in the next cycle.
- Lock hold:
  - Stimulus: `inst_req` alone, `addr_ok`=0 for 3 cycles, `data_req` rises in cycle 2, `addr_ok`=1 in cycle 4.
  - Required: `addr` = `inst_addr` in all 4 cycles, `inst_addr_ok` only in cycle 4. Data is accepted in cycle 5.
- Ordering:
  - Stimulus: accept inst A, data B, inst C, then three `data_ok` pulses with `rdata` = 0x11, 0x22, 0x33.
  - Required: `inst_data_ok`, then `data_data_ok`, then `inst_data_ok`, with matching `rdata`.
- Full:
  - Stimulus: DEPTH=4, four accepts with no `data_ok`, then a fifth `data_req`.
  - Required: `req`=0 while full. `req` reasserts the cycle after the first `data_ok`.
- Flush (macro on):
  - Stimulus: two inst entries and one data entry outstanding, `flush` pulse, then three `data_ok` pulses.
  - Required: zero `inst_data_ok` pulses, exactly one `data_data_ok`, FIFO empty afterwards.
- Reset mid-burst:
  - Stimulus: `resetn`=0 with 3 entries outstanding.
  - Required: after release, FIFO empty, and a `data_ok` produces no `*_data_ok`.
